// File: rtl/keypad_scan.sv
// Scanner and debouncer for a 4x4 active-low key matrix.
// Drives one column low per dwell period and waits for a single-row press
// to stay stable before accepting it. It also waits for the release to stay
// stable before scanning again. Accepted keys are shifted into a 4-digit
// entry register.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   key_row    row lines from the matrix, active-low, asynchronous
//   key_col    column drive, exactly one bit low
//   entry_clr  synchronous clear of entry_data
//   key_code   hex code {row,col} of the last accepted key
//   key_valid  one-cycle pulse per accepted press
//   entry_data last four accepted codes, newest in [3:0]
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  input  logic        entry_clr,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] entry_data
);

  localparam int unsigned TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_c;
  logic [3:0]    key_col_q, key_col_d;
  logic [3:0]    cap_row_q, cap_row_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic [DW-1:0] deb_inc_c, rel_inc_c;
  logic          accept_c;
  logic [3:0]    code_c;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [15:0]   entry_q, entry_d;

  // True when exactly one row line is pulled low.
  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Index of the single low bit (only meaningful when one_low holds).
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  assign tick_c    = (tick_cnt_q == TW'(SCAN_DIV - 1));
  assign deb_inc_c = deb_cnt_q + DW'(1);
  assign rel_inc_c = rel_cnt_q + DW'(1);

  // The column stays held from capture to accept, so the live column index is the captured one.
  assign code_c = {low_idx((state_q == ST_SCAN) ? rs_q : cap_row_q), low_idx(key_col_q)};

  // Row synchronizer and free-running dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 4'hF;
      rs_q       <= 4'hF;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= key_row;
      rs_q       <= sync1_q;
      tick_cnt_q <= tick_c ? '0 : tick_cnt_q + TW'(1);
    end
  end

  // State register and scan/debounce bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      key_col_q   <= 4'b1110;
      cap_row_q   <= 4'hF;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      entry_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      key_col_q   <= key_col_d;
      cap_row_q   <= cap_row_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      entry_q     <= entry_d;
    end
  end

  // Next-state logic; decisions only on tick cycles.
  always_comb begin
    state_d   = state_q;
    key_col_d = key_col_q;
    cap_row_d = cap_row_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    accept_c  = 1'b0;
    if (tick_c) begin
      case (state_q)
        ST_SCAN: begin
          if (one_low(rs_q)) begin
            cap_row_d = rs_q;
            deb_cnt_d = DW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept_c  = 1'b1;
              state_d   = ST_HELD;
              rel_cnt_d = '0;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            key_col_d = {key_col_q[2:0], key_col_q[3]};
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q == cap_row_q) begin
            deb_cnt_d = deb_inc_c;
            if (deb_inc_c == DW'(DEBOUNCE_SCANS)) begin
              accept_c  = 1'b1;
              state_d   = ST_HELD;
              rel_cnt_d = '0;
            end
          end else begin
            key_col_d = {key_col_q[2:0], key_col_q[3]};
            deb_cnt_d = '0;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rs_q == 4'hF) begin
            if (rel_inc_c == DW'(DEBOUNCE_SCANS)) begin
              key_col_d = {key_col_q[2:0], key_col_q[3]};
              rel_cnt_d = '0;
              deb_cnt_d = '0;
              state_d   = ST_SCAN;
            end else begin
              rel_cnt_d = rel_inc_c;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // Output next values; a clear coinciding with an accept keeps only the new code.
  always_comb begin
    key_valid_d = accept_c;
    key_code_d  = key_code_q;
    entry_d     = entry_q;
    if (accept_c) begin
      key_code_d = code_c;
      entry_d    = entry_clr ? {12'h000, code_c} : {entry_q[11:0], code_c};
    end else if (entry_clr) begin
      entry_d = 16'h0000;
    end
  end

  assign key_col    = key_col_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign entry_data = entry_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A small matrix model pulls a row low when a pressed key's column is driven.
module tb_keypad_scan;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic        entry_clr;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] entry_data;

  logic [15:0] pressed;
  logic        ovr;
  logic [3:0]  ovr_row;
  logic [3:0]  mat_row;

  int checks;
  int failures;
  int vcount;

  typedef struct {
    int          key;
    logic [3:0]  code;
    logic [15:0] entry;
  } vec_t;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_row    (key_row),
    .key_col    (key_col),
    .entry_clr  (entry_clr),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .entry_data (entry_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: key r*4+c shorts row r to column c.
  always_comb begin
    mat_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !key_col[c]) mat_row[r] = 1'b0;
  end
  assign key_row = ovr ? ovr_row : mat_row;

  always @(posedge clk) if (rst_n && key_valid) vcount++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns at the negedge right after key_col switches to col.
  task automatic wait_col(input logic [3:0] col, input int budget, output bit ok);
    logic [3:0] prev;
    prev = key_col;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_col == col && prev != col) begin
        ok = 1'b1;
        break;
      end
      prev = key_col;
    end
  endtask

  initial begin
    vec_t       tbl[6];
    logic [3:0] col_seq[4];
    logic [3:0] hold_col, next_col, seen;
    bit         ok;
    int         v0, c;

    checks = 0; failures = 0; vcount = 0;
    pressed = 16'h0; ovr = 1'b0; ovr_row = 4'hF; entry_clr = 1'b0; rst_n = 1'b0;

    tbl[0] = '{6,  4'h6, 16'h0006};
    tbl[1] = '{15, 4'hF, 16'h006F};
    tbl[2] = '{1,  4'h1, 16'h06F1};
    tbl[3] = '{2,  4'h2, 16'h6F12};
    tbl[4] = '{3,  4'h3, 16'hF123};
    tbl[5] = '{4,  4'h4, 16'h1234};
    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_key_col",   16'(key_col),   16'h000E);
    check("rst_key_code",  16'(key_code),  16'h0000);
    check("rst_key_valid", 16'(key_valid), 16'h0000);
    check("rst_entry",     entry_data,     16'h0000);

    // Idle rotation: first tick SD cycles after release
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("idle_col_%0d", i), 16'(key_col), 16'(col_seq[(i/4)%4]));
      @(negedge clk);
    end
    check("idle_no_valid", 16'(vcount), 16'h0000);

    // Accepted key sequence
    for (int i = 0; i < 6; i++) begin
      v0 = vcount;
      c = tbl[i].key % 4;
      hold_col = ~(4'b0001 << c);
      next_col = ~(4'b0001 << ((c + 1) % 4));
      pressed = 16'h0001 << tbl[i].key;
      wait_valid(200, ok);
      check($sformatf("key%0d_timeout", i), 16'(ok), 16'h0001);
      check($sformatf("key%0d_code", i), 16'(key_code), 16'(tbl[i].code));
      check($sformatf("key%0d_entry", i), entry_data, tbl[i].entry);
      repeat (20) @(negedge clk);
      check($sformatf("key%0d_col_held", i), 16'(key_col), 16'(hold_col));
      check($sformatf("key%0d_one_pulse", i), 16'(vcount - v0), 16'h0001);
      pressed = 16'h0;
      repeat (8) @(negedge clk);
      check($sformatf("key%0d_col_rel", i), 16'(key_col), 16'(hold_col));
      wait_col(next_col, 40, ok);
      check($sformatf("key%0d_rotate", i), 16'(ok), 16'h0001);
      repeat (8) @(negedge clk);
    end

    // Clear without accept
    entry_clr = 1'b1;
    @(negedge clk);
    entry_clr = 1'b0;
    check("clr_entry", entry_data, 16'h0000);
    check("clr_code_hold", 16'(key_code), 16'h0004);

    // Two rows low in one column: ignored, rotation continues
    v0 = vcount;
    seen = 4'h0;
    pressed = 16'h0202;
    repeat (60) begin
      @(negedge clk);
      seen = seen | ~key_col;
    end
    check("dual_rotate", 16'(seen), 16'h000F);
    check("dual_no_valid", 16'(vcount - v0), 16'h0000);
    pressed = 16'h0;
    repeat (8) @(negedge clk);

    // Bounce: single-tick presses abandoned
    v0 = vcount;
    wait_col(4'b1110, 40, ok);
    check("bounce_sync", 16'(ok), 16'h0001);
    ovr = 1'b1; ovr_row = 4'b1110;
    repeat (4) @(negedge clk);
    check("bounce_hold1", 16'(key_col), 16'h000E);
    ovr_row = 4'hF;
    repeat (4) @(negedge clk);
    check("bounce_abandon1", 16'(key_col), 16'h000D);
    ovr_row = 4'b1110;
    repeat (4) @(negedge clk);
    check("bounce_hold2", 16'(key_col), 16'h000D);
    ovr_row = 4'hF;
    repeat (4) @(negedge clk);
    check("bounce_abandon2", 16'(key_col), 16'h000B);
    repeat (4) @(negedge clk);
    check("bounce_resume", 16'(key_col), 16'h0007);
    check("bounce_no_valid", 16'(vcount - v0), 16'h0000);
    ovr = 1'b0;

    // Clear on the accept update cycle, then long hold without repeat
    wait_col(4'b1110, 40, ok);
    v0 = vcount;
    pressed = 16'h0200;
    wait_col(4'b1101, 40, ok);
    check("clracc_sync", 16'(ok), 16'h0001);
    repeat (11) @(negedge clk);
    entry_clr = 1'b1;
    @(negedge clk);
    entry_clr = 1'b0;
    check("clracc_valid", 16'(key_valid), 16'h0001);
    check("clracc_code", 16'(key_code), 16'h0009);
    check("clracc_entry", entry_data, 16'h0009);
    repeat (400) @(negedge clk);
    check("hold100_one_pulse", 16'(vcount - v0), 16'h0001);
    pressed = 16'h0;
    repeat (40) @(negedge clk);

    // Reset during debounce, key held across reset
    wait_col(4'b1110, 40, ok);
    pressed = 16'h0020;
    wait_col(4'b1101, 40, ok);
    check("rstdeb_sync", 16'(ok), 16'h0001);
    repeat (6) @(negedge clk);
    v0 = vcount;
    rst_n = 1'b0;
    #1;
    check("rstdeb_col",   16'(key_col),   16'h000E);
    check("rstdeb_code",  16'(key_code),  16'h0000);
    check("rstdeb_valid", 16'(key_valid), 16'h0000);
    check("rstdeb_entry", entry_data,     16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(200, ok);
    check("rstdeb_redetect", 16'(ok), 16'h0001);
    check("rstdeb_new_code", 16'(key_code), 16'h0005);
    check("rstdeb_new_entry", entry_data, 16'h0005);
    repeat (20) @(negedge clk);
    pressed = 16'h0;
    repeat (40) @(negedge clk);
    check("rstdeb_one_pulse", 16'(vcount - v0), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per column dwell (one scan tick per SCAN_DIV cycles), range 2..2^20.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive stable ticks required for both press and release, range 1..15.
REQ-003 clk  input  1  100MHz system clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 key_row  input  4  matrix row lines, active-low (pulled up), asynchronous to clk.
REQ-006 key_col  output  4  column drive, exactly one bit low at any time.
REQ-007 entry_clr  input  1  synchronous clear of entry_data, active-high.
REQ-008 key_code  output  4  hex code of last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse per accepted press.
REQ-010 entry_data  output  16  last four accepted codes; newest in [3:0], suitable to drive a 4-digit display.

Function
REQ-011 key_row shall pass through a 2-flop synchronizer; all row decisions use the synchronized value rs.
REQ-012 Tick counter shall count 0..SCAN_DIV-1 and wrap; tick is high for one cycle when count==SCAN_DIV-1; the counter runs in all states.
REQ-013 Column index c: key_col 1110->c=0, 1101->1, 1011->2, 0111->3; row index r: bit r of rs low.
REQ-014 key_code shall be r*4+c, i.e. {r[1:0],c[1:0]}.
REQ-015 FSM states SCAN, DEBOUNCE, HELD; each decision is taken only on tick cycles; between ticks state and key_col are held.
REQ-016 SCAN, tick, rs has exactly one bit low: capture rs and c, deb_cnt<=1, key_col held; go DEBOUNCE, or, if DEBOUNCE_SCANS==1, accept immediately per REQ-018.
REQ-017 SCAN, tick, rs all high or two or more bits low: key_col rotates left ({key_col[2:0],key_col[3]}); stay SCAN.
REQ-018 DEBOUNCE, tick, rs equals captured: deb_cnt+1; when it reaches DEBOUNCE_SCANS, accept: in the next cycle key_valid=1 for exactly one cycle, key_code updated, entry_data<={entry_data[11:0],code}; go HELD, rel_cnt<=0.
REQ-019 DEBOUNCE, tick, rs differs from captured: abandon with no key_valid; rotate key_col; go SCAN.
REQ-020 HELD, tick: rs all high increments rel_cnt, otherwise rel_cnt<=0; when rel_cnt reaches DEBOUNCE_SCANS, rotate key_col and go SCAN; key_col stays fixed while HELD.
REQ-021 Any number of ticks in HELD shall produce no further key_valid (no auto-repeat).
REQ-022 entry_clr with no simultaneous accept sets entry_data to 0; if it coincides with the accept update cycle, entry_data becomes {12'h000,code}.
REQ-023 key_code and entry_data change only on accept or clear; they hold otherwise.
REQ-024 Counter widths derive from parameters; no arithmetic overflow at the maximum parameter values.

Reset
REQ-025 While rst_n is low: key_col=4'b1110, key_code=0, key_valid=0, entry_data=16'h0000, synchronizer=4'hF, tick count=0, deb_cnt=rel_cnt=0, state SCAN.
REQ-026 Reset asserted mid-debounce or mid-hold shall discard the pending key and emit no key_valid after release.
REQ-027 The first tick after reset release occurs SCAN_DIV cycles later.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-028 No key pressed for 32 cycles -> key_col cycles 1110,1101,1011,0111,1110, changing every 4 cycles; key_valid never asserts.
REQ-029 Hold row1 low while key_col=1011 (c=2) for at least 3 ticks -> one key_valid pulse, key_code=4'h6, entry_data=16'h0006; key_col stays 1011 until row1 is high for 3 ticks, then rotates to 0111.
REQ-030 Accept keys F,1,2,3 in sequence -> entry_data=16'hF123; 5th key 4 -> 16'h1234; entry_clr -> 16'h0000.
REQ-031 Bounce: row low for 1 tick, high, low for 1 tick -> no key_valid; scanning resumes rotation.
REQ-032 Two rows low in the same column -> treated as no press, rotation continues; key held 100 ticks -> exactly one key_valid; entry_clr asserted on the accept update cycle -> entry_data=code.
REQ-033 rst_n pulsed low during DEBOUNCE -> all outputs at reset values; a key held across reset is re-detected fresh and accepted once.
